// File: rtl/keypad_scanner_fifo_if.sv
// rtl/keypad_scanner_fifo_if.sv - key code stream handshake between scanner FIFO and consumer
//
// Ports / members:
//   key_code  : FIFO head code (row*COLS + col), driven by the scanner
//   key_valid : FIFO non-empty, driven by the scanner
//   key_ready : consumer accepts the head, driven by the consumer
// Modports: master (scanner side), slave (consumer side).
interface keypad_scanner_fifo_if #(
  parameter int KW = 4
) ();
  logic [KW-1:0] key_code;
  logic          key_valid;
  logic          key_ready;

  modport master (output key_code, output key_valid, input key_ready);
  modport slave  (input key_code, input key_valid, output key_ready);
endinterface

// File: rtl/keypad_scanner_fifo.sv
// rtl/keypad_scanner_fifo.sv - matrix keypad scanner with frame debounce, ghost rejection and FWFT key FIFO
//
// Ports:
//   clk, rst       : clock, asynchronous active-low reset
//   matricial_col  : column sense lines, active-low, asynchronous
//   matricial_lin  : row drive lines, active-low one-hot while scanning
//   key_if         : master side of the key code stream (key_code/key_valid/key_ready)
//   key_held       : debounced frame state is a single key
//   fifo_count     : FIFO occupancy
//   overflow       : one-cycle pulse when a key code is dropped on a full FIFO
module keypad_scanner_fifo #(
  parameter int ROWS           = 4,
  parameter int COLS           = 4,
  parameter int SCAN_CYCLES    = 1000,
  parameter int DEBOUNCE_SCANS = 4,
  parameter int REPEAT_SCANS   = 0,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [COLS-1:0]               matricial_col,
  output logic [ROWS-1:0]               matricial_lin,
  keypad_scanner_fifo_if.master         key_if,
  output logic                          key_held,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow
);
  localparam int KW   = $clog2(ROWS*COLS);
  localparam int RW   = $clog2(ROWS);
  localparam int CW   = $clog2(SCAN_CYCLES);
  localparam int COLW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int DW   = $clog2(DEBOUNCE_SCANS+1);
  localparam int RPW  = (REPEAT_SCANS > 0) ? $clog2(REPEAT_SCANS+1) : 1;

  typedef enum logic [1:0] {K_NONE, K_SINGLE, K_MULTI} kind_t;

  // Column synchroniser
  logic [COLS-1:0] col_s1, col_s2;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col_s1 <= '1;
      col_s2 <= '1;
    end else begin
      col_s1 <= matricial_col;
      col_s2 <= col_s1;
    end
  end

  // Row / cycle counters; the row drive is registered so it lags the counter by one clock,
  // which gives each row the full SCAN_CYCLES window and lets the synchroniser settle
  // before the sample on the last counter cycle.
  logic [RW-1:0] row;
  logic [CW-1:0] cyc;
  logic          sample;
  logic          last_row;

  assign sample   = (cyc == CW'(SCAN_CYCLES-1));
  assign last_row = (row == RW'(ROWS-1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      row           <= '0;
      cyc           <= '0;
      matricial_lin <= '1;
    end else begin
      matricial_lin <= ~(ROWS'(1) << row);
      if (sample) begin
        cyc <= '0;
        row <= last_row ? '0 : row + RW'(1);
      end else begin
        cyc <= cyc + CW'(1);
      end
    end
  end

  // Per-row analysis: low-bit count saturating at 2 plus the column of the last low bit
  logic [1:0]      row_ones;
  logic [COLW-1:0] row_idx;
  always_comb begin
    row_ones = 2'd0;
    row_idx  = '0;
    for (int c = 0; c < COLS; c++) begin
      if (!col_s2[c]) begin
        if (row_ones != 2'd2) row_ones = row_ones + 2'd1;
        row_idx = COLW'(c);
      end
    end
  end

  // Frame accumulation across the sweep
  logic [1:0]    acc_ones, tot_ones;
  logic [2:0]    ones_sum;
  logic [KW-1:0] acc_code, cur_code;
  always_comb begin
    ones_sum = {1'b0, acc_ones} + {1'b0, row_ones};
    tot_ones = (ones_sum > 3'd2) ? 2'd2 : ones_sum[1:0];
    cur_code = (row_ones == 2'd1) ? KW'(int'(row) * COLS + int'(row_idx)) : acc_code;
  end

  kind_t         frame_kind;
  logic [KW-1:0] frame_code;
  logic          frame_done;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_ones   <= '0;
      acc_code   <= '0;
      frame_kind <= K_NONE;
      frame_code <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (sample) begin
        if (last_row) begin
          frame_kind <= (tot_ones == 2'd0) ? K_NONE : (tot_ones == 2'd1) ? K_SINGLE : K_MULTI;
          frame_code <= cur_code;
          frame_done <= 1'b1;
          acc_ones   <= '0;
          acc_code   <= '0;
        end else begin
          acc_ones <= tot_ones;
          acc_code <= cur_code;
        end
      end
    end
  end

  // Debounce and event generation, one clock after the frame result registers
  kind_t          prev_kind, prev_kind_n, deb_kind, deb_kind_n;
  logic [KW-1:0]  prev_code, prev_code_n, deb_code, deb_code_n;
  logic [DW-1:0]  stable_cnt, stable_cnt_n;
  logic [RPW-1:0] rep_cnt, rep_cnt_n;
  logic           push, same, changed;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prev_kind  <= K_NONE;
      prev_code  <= '0;
      deb_kind   <= K_NONE;
      deb_code   <= '0;
      stable_cnt <= '0;
      rep_cnt    <= '0;
    end else begin
      prev_kind  <= prev_kind_n;
      prev_code  <= prev_code_n;
      deb_kind   <= deb_kind_n;
      deb_code   <= deb_code_n;
      stable_cnt <= stable_cnt_n;
      rep_cnt    <= rep_cnt_n;
    end
  end

  always_comb begin
    prev_kind_n  = prev_kind;
    prev_code_n  = prev_code;
    deb_kind_n   = deb_kind;
    deb_code_n   = deb_code;
    stable_cnt_n = stable_cnt;
    rep_cnt_n    = rep_cnt;
    push         = 1'b0;
    same         = 1'b0;
    changed      = 1'b0;
    if (frame_done) begin
      // Codes only matter for SINGLE; NONE/MULTI frames compare on kind alone
      same = (frame_kind == prev_kind) && (frame_kind != K_SINGLE || frame_code == prev_code);
      if (!same)
        stable_cnt_n = DW'(1);
      else if (stable_cnt != DW'(DEBOUNCE_SCANS))
        stable_cnt_n = stable_cnt + DW'(1);
      prev_kind_n = frame_kind;
      prev_code_n = frame_code;
      if (stable_cnt_n == DW'(DEBOUNCE_SCANS)) begin
        deb_kind_n = frame_kind;
        deb_code_n = frame_code;
      end
      changed = (deb_kind_n != deb_kind) || (deb_kind_n == K_SINGLE && deb_code_n != deb_code);
      if (changed) begin
        rep_cnt_n = '0;
        push      = (deb_kind_n == K_SINGLE);
      end else if (REPEAT_SCANS > 0 && deb_kind == K_SINGLE) begin
        if (int'(rep_cnt) == REPEAT_SCANS - 1) begin
          rep_cnt_n = '0;
          push      = 1'b1;
        end else begin
          rep_cnt_n = rep_cnt + RPW'(1);
        end
      end
    end
  end

  assign key_held = (deb_kind == K_SINGLE);

  // First-word-fall-through FIFO
  logic [KW-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          full, pop, do_push;

  assign full             = (fifo_count == (AW+1)'(FIFO_DEPTH));
  assign key_if.key_valid = (fifo_count != '0);
  assign key_if.key_code  = key_if.key_valid ? mem[rd_ptr] : '0;
  assign pop              = key_if.key_valid && key_if.key_ready;
  // A pop on the same edge frees the slot, so a full FIFO still accepts the push
  assign do_push          = push && (!full || pop);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      overflow   <= 1'b0;
    end else begin
      overflow <= push && full && !pop;
      if (do_push) begin
        mem[wr_ptr] <= deb_code_n;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end
endmodule

// File: tb/tb_keypad_scanner_fifo.sv
// tb/tb_keypad_scanner_fifo.sv - scoreboard bench for keypad_scanner_fifo
module tb_keypad_scanner_fifo;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [15:0] keys, keys2;
  logic [3:0]  col, col2, lin, lin2;
  logic        held, held2, ovf, ovf2;
  logic [2:0]  cnt, cnt2;

  int tests = 0;
  int fails = 0;
  int ovf_cnt = 0;
  int pops2 = 0;
  longint cyc = 0;
  longint last_pop2 = -1;
  int exp_q[$];
  int exp_q2[$];

  keypad_scanner_fifo_if #(.KW(4)) kif ();
  keypad_scanner_fifo_if #(.KW(4)) kif2 ();

  keypad_scanner_fifo #(.ROWS(4), .COLS(4), .SCAN_CYCLES(4), .DEBOUNCE_SCANS(4),
                        .REPEAT_SCANS(0), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .matricial_col(col), .matricial_lin(lin),
    .key_if(kif.master), .key_held(held), .fifo_count(cnt), .overflow(ovf));

  keypad_scanner_fifo #(.ROWS(4), .COLS(4), .SCAN_CYCLES(4), .DEBOUNCE_SCANS(4),
                        .REPEAT_SCANS(8), .FIFO_DEPTH(4)) dut_rep (
    .clk(clk), .rst(rst), .matricial_col(col2), .matricial_lin(lin2),
    .key_if(kif2.master), .key_held(held2), .fifo_count(cnt2), .overflow(ovf2));

  // Keypad matrix: a pressed key pulls its column low while its row is driven low
  function automatic logic [3:0] pad(input logic [3:0] l, input logic [15:0] k);
    logic [3:0] c;
    c = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int j = 0; j < 4; j++)
        if (!l[r] && k[r*4+j]) c[j] = 1'b0;
    return c;
  endfunction
  assign col  = pad(lin, keys);
  assign col2 = pad(lin2, keys2);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) if (ovf === 1'b1) ovf_cnt++;

  // Scoreboard monitors
  always @(negedge clk) begin
    if (kif.key_valid === 1'b1 && kif.key_ready === 1'b1) begin
      if (exp_q.size() == 0) check("unexpected_pop", 32'(kif.key_code), 32'hFFFF);
      else check("pop_code", 32'(kif.key_code), 32'(exp_q.pop_front()));
    end
  end

  always @(negedge clk) begin
    if (kif2.key_valid === 1'b1 && kif2.key_ready === 1'b1) begin
      if (exp_q2.size() == 0) check("unexpected_pop_rep", 32'(kif2.key_code), 32'hFFFF);
      else check("pop_code_rep", 32'(kif2.key_code), 32'(exp_q2.pop_front()));
      if (last_pop2 >= 0) check("repeat_interval", 32'(cyc - last_pop2), 128);
      last_pop2 = cyc;
      pops2++;
    end
  end

  task automatic wait_frames(input int n);
    repeat (16*n) @(posedge clk);
    #1;
  endtask

  // Returns at the negedge just after a 0111 -> 1110 row-drive transition (frame start)
  task automatic wait_frame_start(input bit sel);
    logic [3:0] p;
    bit found;
    found = 0;
    p = sel ? lin2 : lin;
    for (int i = 0; i < 64 && !found; i++) begin
      @(negedge clk);
      if (p == 4'b0111 && (sel ? lin2 : lin) == 4'b1110) found = 1;
      else p = sel ? lin2 : lin;
    end
    if (!found) check("frame_start_timeout", 0, 1);
  endtask

  task automatic tap(input int k, input bit expect_push);
    keys = 16'(1) << k;
    if (expect_push) exp_q.push_back(k);
    wait_frames(7);
    keys = '0;
    wait_frames(7);
  endtask

  initial begin
    logic [3:0] e;
    rst = 1'b0;
    keys = '0;
    keys2 = '0;
    kif.key_ready = 1'b1;
    kif2.key_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_lin", 32'(lin), 32'hF);
    check("rst_valid", 32'(kif.key_valid), 0);
    check("rst_code", 32'(kif.key_code), 0);
    check("rst_held", 32'(held), 0);
    check("rst_count", 32'(cnt), 0);
    check("rst_ovf", 32'(ovf), 0);

    // 1: row scan sequence
    @(negedge clk) rst = 1'b1;
    for (int n = 0; n < 32; n++) begin
      @(posedge clk);
      #1;
      e = ~(4'b0001 << ((n / 4) % 4));
      check("lin_seq", 32'(lin), 32'(e));
    end
    check("idle_valid", 32'(kif.key_valid), 0);
    check("idle_held", 32'(held), 0);

    // 2: single key 9
    keys = 16'(1) << 9;
    exp_q.push_back(9);
    wait_frames(8);
    check("held_9", 32'(held), 1);
    keys = '0;
    wait_frames(3);
    check("held_9_debouncing", 32'(held), 1);
    wait_frames(5);
    check("released_9", 32'(held), 0);
    check("count_after_9", 32'(cnt), 0);

    // 3: bounce key 5 then hold
    exp_q.push_back(5);
    for (int b = 0; b < 2; b++) begin
      keys = 16'(1) << 5;
      wait_frames(1);
      keys = '0;
      wait_frames(1);
    end
    keys = 16'(1) << 5;
    wait_frames(8);
    check("held_5", 32'(held), 1);
    keys = '0;
    wait_frames(8);

    // 4: ghost pattern, then single key 0
    keys = 16'h0021;
    wait_frames(8);
    check("multi_held", 32'(held), 0);
    check("multi_count", 32'(cnt), 0);
    keys = 16'h0001;
    exp_q.push_back(0);
    wait_frames(8);
    check("held_0", 32'(held), 1);
    keys = '0;
    wait_frames(8);

    // 5: overflow and drain
    kif.key_ready = 1'b0;
    ovf_cnt = 0;
    tap(1, 1); tap(2, 1); tap(3, 1); tap(4, 1); tap(6, 0);
    check("full_count", 32'(cnt), 4);
    check("overflow_pulses", 32'(ovf_cnt), 1);
    check("full_head", 32'(kif.key_code), 1);
    kif.key_ready = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    check("drained_count", 32'(cnt), 0);
    check("drained_queue", 32'(exp_q.size()), 0);

    kif.key_ready = 1'b0;
    tap(7, 1); tap(8, 1); tap(10, 1); tap(11, 1);
    check("refill_count", 32'(cnt), 4);
    wait_frame_start(0);
    keys = 16'(1) << 12;
    exp_q.push_back(12);
    repeat (3) wait_frame_start(0);
    repeat (15) @(posedge clk);
    #1;
    kif.key_ready = 1'b1;
    @(posedge clk);
    #1;
    kif.key_ready = 1'b0;
    check("push_pop_full_count", 32'(cnt), 4);
    check("push_pop_full_ovf", 32'(ovf_cnt), 1);
    keys = '0;
    wait_frames(7);
    kif.key_ready = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    check("final_drain_count", 32'(cnt), 0);
    check("final_drain_queue", 32'(exp_q.size()), 0);

    // 6: auto-repeat on key 15
    wait_frame_start(1);
    keys2 = 16'(1) << 15;
    repeat (5) exp_q2.push_back(15);
    repeat (38) wait_frame_start(1);
    keys2 = '0;
    wait_frames(10);
    check("repeat_pushes", 32'(pops2), 5);
    check("repeat_queue", 32'(exp_q2.size()), 0);
    check("repeat_released", 32'(held2), 0);

    // 7: asynchronous reset with FIFO contents and a held key
    kif.key_ready = 1'b0;
    keys = 16'(1) << 13;
    exp_q.push_back(13);
    wait_frames(8);
    check("pre_reset_count", 32'(cnt), 1);
    check("pre_reset_held", 32'(held), 1);
    @(posedge clk);
    #3;
    rst = 1'b0;
    exp_q.delete();
    #1;
    check("async_rst_count", 32'(cnt), 0);
    check("async_rst_valid", 32'(kif.key_valid), 0);
    check("async_rst_held", 32'(held), 0);
    check("async_rst_lin", 32'(lin), 32'hF);
    keys = '0;
    repeat (2) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
